subgame_ctrl: RTL and testbench
===============================

Name: subgame_ctrl

Overview:
Game controller for the two-player subtraction game; owns the game state that the seven_segment display driver renders. It latches the setup configuration and sequences turns. It validates take/add moves against the pile and limits, detects the win, and drives the hide request for hidden-pile mode. All outputs are registered and feed seven_segment directly, with `pile_size`, `plr_turn`, `win`, `max_sub`, `max_add` and `hide` connected one-to-one.

Parameters:
- `START_PILE`, default 21: pile used when `cfg_pile` is 0.
- `ADD_CREDITS`, default 2: add moves allowed per player per game (range 0-3).
- `REVEAL_TICKS`, default 3: `tick` pulses after a valid move before the pile is hidden.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `tick`  in  1  one-cycle enable pulse (1 Hz) for the reveal timer
- `btn_start`  in  1  one-cycle pulse (debounced upstream); starts the game, or returns to setup from WIN
- `btn_take`  in  1  one-cycle pulse; subtract `move_amt` from the pile
- `btn_add`  in  1  one-cycle pulse; add `move_amt` to the pile
- `move_amt`  in  3  move size from switches
- `cfg_pile`  in  7  initial pile setting
- `cfg_sub`  in  3  max take per move setting
- `cfg_add`  in  3  max add per move setting
- `hide_mode`  in  1  enables hidden-pile play
- `pile_size`  out  7  current pile, 0-99
- `plr_turn`  out  1  player to move (0 = P1, 1 = P2); in WIN, holds the winner
- `win`  out  1  game over
- `max_sub`  out  3  latched take limit
- `max_add`  out  3  latched add limit
- `hide`  out  1  request the display to blank the pile digits
- `add_left`  out  2  add credits remaining for `plr_turn`
- `move_err`  out  1  one-cycle pulse on a rejected move

Behaviour:
- States: SETUP, PLAY, WIN. Outputs update on the clock edge after the triggering input, i.e. 1-cycle latency.
- Reset (`rst_n` low at a `clk` edge, valid in any state, mid-game included):
  - state = SETUP, `pile_size` = START_PILE, `plr_turn` = 0, `win` = 0, `hide` = 0, `move_err` = 0.
  - `max_sub` = 3, `max_add` = 2, both credit counters = ADD_CREDITS.
- Config clamping, applied in SETUP:
  - pile: 0 → START_PILE; >99 → 99.
  - sub and add limits: 0 → 1.
- SETUP:
  - Every cycle, `pile_size`, `max_sub` and `max_add` follow the clamped configuration.
  - `btn_take` / `btn_add` are ignored; no error pulse.
  - `btn_start` → PLAY. On entry: latch `hide_mode`, `plr_turn` = 0, credits = ADD_CREDITS, reveal counter = 0.
- PLAY, take:
  - Valid iff 1 ≤ `move_amt` ≤ `max_sub` and `move_amt` ≤ `pile_size`.
  - Effect: pile -= `move_amt`.
  - If the pile becomes 0 → WIN: `win` = 1, `plr_turn` unchanged (the mover wins). Otherwise `plr_turn` toggles.
- PLAY, add:
  - Valid iff 1 ≤ `move_amt` ≤ `max_add`, `pile_size` + `move_amt` ≤ 99, and the mover's credits > 0.
  - Effect: pile += `move_amt` (7-bit result, never exceeds 99), mover's credit − 1, `plr_turn` toggles.
- PLAY, rejection:
  - `btn_take` and `btn_add` in the same cycle → both rejected.
  - Any invalid move → `move_err` = 1 for one cycle; no state change.
- Hide:
  - `hide` = 1 only in PLAY with latched `hide_mode` = 1 and reveal counter ≥ REVEAL_TICKS.
  - The counter increments on `tick` and saturates at REVEAL_TICKS. A valid move clears it, so `hide` drops the following cycle.
  - `hide` = 0 in SETUP and WIN.
- WIN:
  - `pile_size` = 0 and `win` = 1 are held; moves are ignored with no error pulse.
  - `btn_start` → SETUP with `win` = 0.
  - `btn_start` coincident with a move in PLAY: start is ignored, the move is processed.

Decomposition:
- Shared package `subgame_pkg`:
  - State enum (SETUP, PLAY, WIN).
  - Constant MAX_PILE = 99.
  - Reset defaults DEF_MAX_SUB = 3 and DEF_MAX_ADD = 2.
- One sub-module, `reveal_timer`: `tick`-driven saturating counter with clear and enable; outputs `hide`.

Test Plan:
- Reset mid-game (pile 10, P2 to move), then `rst_n` low one cycle → `pile_size` = 21, `plr_turn` = 0, `win` = 0, SETUP, credits = 2.
- Config `cfg_pile` = 120, `cfg_sub` = 0, `cfg_add` = 4, then start → `pile_size` = 99, `max_sub` = 1, `max_add` = 4, PLAY.
- Pile 7, `max_sub` = 3; P1 takes 3, P2 takes 3, P1 takes 1 → pile 4, 1, 0; `win` = 1, `plr_turn` = 0; later moves ignored; `btn_start` → SETUP, `win` = 0.
- Pile 98: add 2 → `move_err` pulse, pile stays 98. Take 4 with `max_sub` = 3 → `move_err`. Take and add same cycle → `move_err`, no change.
- P1 adds 1 three times with ADD_CREDITS = 2, interleaved with P2 takes → third add rejected, `add_left` = 0 shown on P1's turn.
- `hide_mode` = 1: 3 `tick` pulses → `hide` = 1; valid take → `hide` = 0 next cycle; 2 ticks → still 0; 1 more → 1.

Source files
------------

// File: rtl/subgame_pkg.sv
// Shared types and constants for the subtraction-game controller.
// Holds the FSM state encoding, pile/limit constants and the setup clamp helpers.
package subgame_pkg;

   typedef enum logic [1:0] {
      SETUP = 2'd0,
      PLAY  = 2'd1,
      WIN   = 2'd2
   } state_t;

   localparam logic [6:0] MAX_PILE    = 7'd99;
   localparam logic [2:0] DEF_MAX_SUB = 3'd3;
   localparam logic [2:0] DEF_MAX_ADD = 3'd2;

   // Zero selects the default pile; anything above the display range saturates.
   function automatic logic [6:0] clamp_pile(input logic [6:0] cfg, input logic [6:0] dflt);
      if (cfg == 7'd0)
         return dflt;
      else if (cfg > MAX_PILE)
         return MAX_PILE;
      else
         return cfg;
   endfunction

   function automatic logic [2:0] clamp_limit(input logic [2:0] cfg);
      return (cfg == 3'd0) ? 3'd1 : cfg;
   endfunction

endpackage

// File: rtl/subgame_ctrl_if.sv
// Player/display-facing signal bundle for subgame_ctrl.
// The master side drives buttons and configuration; the slave side is the controller.
interface subgame_ctrl_if;

   logic       tick;
   logic       btn_start;
   logic       btn_take;
   logic       btn_add;
   logic [2:0] move_amt;
   logic [6:0] cfg_pile;
   logic [2:0] cfg_sub;
   logic [2:0] cfg_add;
   logic       hide_mode;

   logic [6:0] pile_size;
   logic       plr_turn;
   logic       win;
   logic [2:0] max_sub;
   logic [2:0] max_add;
   logic       hide;
   logic [1:0] add_left;
   logic       move_err;

   modport master (
      output tick, btn_start, btn_take, btn_add, move_amt,
             cfg_pile, cfg_sub, cfg_add, hide_mode,
      input  pile_size, plr_turn, win, max_sub, max_add,
             hide, add_left, move_err
   );

   modport slave (
      input  tick, btn_start, btn_take, btn_add, move_amt,
             cfg_pile, cfg_sub, cfg_add, hide_mode,
      output pile_size, plr_turn, win, max_sub, max_add,
             hide, add_left, move_err
   );

endinterface

// File: rtl/reveal_timer.sv
// Saturating tick counter that requests the pile be hidden once the reveal
// window after the last valid move has elapsed.
module reveal_timer #(
   parameter int unsigned REVEAL_TICKS = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hide
);

   localparam int unsigned      CW  = $clog2(REVEAL_TICKS + 2);
   localparam logic [CW-1:0]    SAT = CW'(REVEAL_TICKS);

   logic [CW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_tick && (r_cnt != SAT))
         r_cnt <= r_cnt + CW'(1);
   end

   assign o_hide = i_en && (r_cnt == SAT);

endmodule

// File: rtl/subgame_ctrl.sv
// Two-player subtraction-game controller: latches setup, validates take/add
// moves, sequences turns, detects the win and drives the hidden-pile request.
module subgame_ctrl #(
   parameter int unsigned START_PILE   = 21,
   parameter int unsigned ADD_CREDITS  = 2,
   parameter int unsigned REVEAL_TICKS = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   subgame_ctrl_if.slave  bus
);

   import subgame_pkg::*;

   localparam logic [6:0] START_P = 7'(START_PILE);
   localparam logic [1:0] CREDITS = 2'(ADD_CREDITS);

   state_t          r_state;
   logic [6:0]      r_pile;
   logic            r_turn;
   logic            r_win;
   logic            r_hide_mode;
   logic            r_move_err;
   logic [2:0]      r_max_sub;
   logic [2:0]      r_max_add;
   logic [1:0][1:0] r_credits;

   logic [6:0] w_cfg_pile;
   logic [2:0] w_cfg_sub;
   logic [2:0] w_cfg_add;
   logic [7:0] w_pile_sum;
   logic [6:0] w_pile_diff;
   logic       w_is_move;
   logic       w_take_ok;
   logic       w_add_ok;
   logic       w_timer_en;
   logic       w_timer_clr;
   logic       w_hide;

   assign w_cfg_pile  = clamp_pile(bus.cfg_pile, START_P);
   assign w_cfg_sub   = clamp_limit(bus.cfg_sub);
   assign w_cfg_add   = clamp_limit(bus.cfg_add);
   assign w_pile_sum  = {1'b0, r_pile} + {5'd0, bus.move_amt};
   assign w_pile_diff = r_pile - {4'd0, bus.move_amt};
   assign w_is_move   = bus.btn_take || bus.btn_add;

   // Simultaneous take and add cancel each other and fall through as an error.
   always_comb begin
      // NOTE: defaults first so no path leaves these unassigned (no latches).
      w_take_ok = 1'b0;
      w_add_ok  = 1'b0;
      if (r_state == PLAY) begin
         w_take_ok = bus.btn_take && !bus.btn_add
                     && (bus.move_amt != 3'd0)
                     && (bus.move_amt <= r_max_sub)
                     && ({4'd0, bus.move_amt} <= r_pile);
         w_add_ok  = bus.btn_add && !bus.btn_take
                     && (bus.move_amt != 3'd0)
                     && (bus.move_amt <= r_max_add)
                     && (w_pile_sum <= {1'b0, MAX_PILE})
                     && (r_credits[r_turn] != 2'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= SETUP;
         r_pile      <= START_P;
         r_turn      <= 1'b0;
         r_win       <= 1'b0;
         r_hide_mode <= 1'b0;
         r_move_err  <= 1'b0;
         r_max_sub   <= DEF_MAX_SUB;
         r_max_add   <= DEF_MAX_ADD;
         r_credits   <= {CREDITS, CREDITS};
      end else begin
         r_move_err <= 1'b0;
         case (r_state)
            SETUP: begin
               r_pile    <= w_cfg_pile;
               r_max_sub <= w_cfg_sub;
               r_max_add <= w_cfg_add;
               if (bus.btn_start) begin
                  r_state     <= PLAY;
                  r_hide_mode <= bus.hide_mode;
                  r_turn      <= 1'b0;
                  r_credits   <= {CREDITS, CREDITS};
               end
            end
            PLAY: begin
               if (w_take_ok) begin
                  r_pile <= w_pile_diff;
                  if (w_pile_diff == 7'd0) begin
                     r_state <= WIN;
                     r_win   <= 1'b1;
                  end else begin
                     r_turn <= ~r_turn;
                  end
               end else if (w_add_ok) begin
                  r_pile            <= w_pile_sum[6:0];
                  r_credits[r_turn] <= r_credits[r_turn] - 2'd1;
                  r_turn            <= ~r_turn;
               end else if (w_is_move) begin
                  r_move_err <= 1'b1;
               end
            end
            WIN: begin
               r_pile <= 7'd0;
               if (bus.btn_start) begin
                  r_state <= SETUP;
                  r_win   <= 1'b0;
                  r_turn  <= 1'b0;
               end
            end
            default: r_state <= SETUP;
         endcase
      end
   end

   assign w_timer_en  = (r_state == PLAY) && r_hide_mode;
   assign w_timer_clr = (r_state != PLAY) || w_take_ok || w_add_ok;

   reveal_timer #(
      .REVEAL_TICKS (REVEAL_TICKS)
   ) u_reveal_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_tick (bus.tick),
      .i_clr  (w_timer_clr),
      .i_en   (w_timer_en),
      .o_hide (w_hide)
   );

   assign bus.pile_size = r_pile;
   assign bus.plr_turn  = r_turn;
   assign bus.win       = r_win;
   assign bus.max_sub   = r_max_sub;
   assign bus.max_add   = r_max_add;
   assign bus.hide      = w_hide;
   assign bus.add_left  = r_credits[r_turn];
   assign bus.move_err  = r_move_err;

endmodule

// File: tb/tb_subgame_ctrl.sv
// Directed-vector bench for subgame_ctrl with hand-computed expectations.
module tb_subgame_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   subgame_ctrl_if bus ();

   subgame_ctrl #(
      .START_PILE   (21),
      .ADD_CREDITS  (2),
      .REVEAL_TICKS (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after an edge; outputs are read at the same point.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_take(input int amt);
      bus.move_amt = 3'(amt);
      bus.btn_take = 1'b1;
      cyc();
      bus.btn_take = 1'b0;
   endtask

   task automatic do_add(input int amt);
      bus.move_amt = 3'(amt);
      bus.btn_add  = 1'b1;
      cyc();
      bus.btn_add  = 1'b0;
   endtask

   task automatic do_start();
      bus.btn_start = 1'b1;
      cyc();
      bus.btn_start = 1'b0;
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         cyc();
         bus.tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic set_cfg(input int p, input int s, input int a);
      bus.cfg_pile = 7'(p);
      bus.cfg_sub  = 3'(s);
      bus.cfg_add  = 3'(a);
   endtask

   initial begin
      bus.tick      = 1'b0;
      bus.btn_start = 1'b0;
      bus.btn_take  = 1'b0;
      bus.btn_add   = 1'b0;
      bus.move_amt  = 3'd0;
      bus.hide_mode = 1'b0;
      set_cfg(0, 3, 2);

      // Power-on reset
      cyc();
      cyc();
      rst_n = 1'b1;
      check("rst_pile",     bus.pile_size, 21);
      check("rst_turn",     bus.plr_turn,  0);
      check("rst_win",      bus.win,       0);
      check("rst_hide",     bus.hide,      0);
      check("rst_err",      bus.move_err,  0);
      check("rst_max_sub",  bus.max_sub,   3);
      check("rst_max_add",  bus.max_add,   2);
      check("rst_add_left", bus.add_left,  2);

      // Moves are ignored in SETUP
      do_take(1);
      check("setup_take_err",  bus.move_err,  0);
      check("setup_take_pile", bus.pile_size, 21);
      do_add(1);
      check("setup_add_err",   bus.move_err,  0);

      // Config clamping, then start
      set_cfg(120, 0, 4);
      cyc();
      check("clamp_pile", bus.pile_size, 99);
      check("clamp_sub",  bus.max_sub,   1);
      check("clamp_add",  bus.max_add,   4);
      do_start();
      check("start_pile", bus.pile_size, 99);
      check("start_turn", bus.plr_turn,  0);
      do_take(1);
      check("play_take_pile", bus.pile_size, 98);
      check("play_take_turn", bus.plr_turn,  1);
      check("play_take_err",  bus.move_err,  0);

      // Overflow add, limit breaches, simultaneous buttons
      do_add(2);
      check("ovf_add_err",  bus.move_err,  1);
      check("ovf_add_pile", bus.pile_size, 98);
      check("ovf_add_turn", bus.plr_turn,  1);
      cyc();
      check("err_one_cycle", bus.move_err, 0);
      do_add(1);
      check("add_to_99_pile", bus.pile_size, 99);
      check("add_to_99_turn", bus.plr_turn,  0);
      check("add_to_99_left", bus.add_left,  2);
      do_take(2);
      check("take_over_max_err",  bus.move_err,  1);
      check("take_over_max_pile", bus.pile_size, 99);
      do_take(0);
      check("take_zero_err", bus.move_err, 1);
      bus.move_amt = 3'd1;
      bus.btn_take = 1'b1;
      bus.btn_add  = 1'b1;
      cyc();
      bus.btn_take = 1'b0;
      bus.btn_add  = 1'b0;
      check("both_err",  bus.move_err,  1);
      check("both_pile", bus.pile_size, 99);
      check("both_turn", bus.plr_turn,  0);

      // Mid-game reset: reach pile 10 with P2 to move and P1 credit spent
      set_cfg(11, 3, 2);
      do_reset();
      cyc();
      check("setup_follow_pile", bus.pile_size, 11);
      check("setup_follow_sub",  bus.max_sub,   3);
      do_start();
      do_add(1);
      check("mg_add_pile", bus.pile_size, 12);
      check("mg_add_turn", bus.plr_turn,  1);
      do_take(4);
      check("mg_take4_err",  bus.move_err,  1);
      check("mg_take4_pile", bus.pile_size, 12);
      do_take(1);
      check("mg_p1_left", bus.add_left, 1);
      do_take(1);
      check("mg_pile10", bus.pile_size, 10);
      check("mg_turn_p2", bus.plr_turn, 1);
      bus.cfg_pile = 7'd0;
      do_reset();
      check("mgrst_pile",     bus.pile_size, 21);
      check("mgrst_turn",     bus.plr_turn,  0);
      check("mgrst_win",      bus.win,       0);
      check("mgrst_add_left", bus.add_left,  2);
      do_take(1);
      check("mgrst_setup_pile", bus.pile_size, 21);

      // Win sequence from pile 7
      set_cfg(7, 3, 2);
      cyc();
      do_start();
      do_take(3);
      check("win_p4",  bus.pile_size, 4);
      do_take(3);
      check("win_p1",  bus.pile_size, 1);
      do_take(1);
      check("win_p0",   bus.pile_size, 0);
      check("win_flag", bus.win,       1);
      check("win_turn", bus.plr_turn,  0);
      do_take(1);
      check("win_take_ign_err",  bus.move_err,  0);
      check("win_take_ign_pile", bus.pile_size, 0);
      check("win_take_ign_win",  bus.win,       1);
      do_add(1);
      check("win_add_ign_err",  bus.move_err,  0);
      check("win_add_ign_pile", bus.pile_size, 0);
      do_start();
      check("win_exit_win", bus.win, 0);
      cyc();
      check("win_exit_setup_pile", bus.pile_size, 7);

      // Add credits exhaust after two adds by P1
      set_cfg(20, 3, 2);
      cyc();
      do_start();
      do_add(1);
      do_take(1);
      check("cr_left1", bus.add_left, 1);
      do_add(1);
      do_take(1);
      check("cr_left0", bus.add_left,  0);
      check("cr_turn",  bus.plr_turn,  0);
      do_add(1);
      check("cr_third_err",  bus.move_err,  1);
      check("cr_third_pile", bus.pile_size, 20);
      check("cr_third_turn", bus.plr_turn,  0);
      do_ticks(4);
      check("nohide_mode", bus.hide, 0);

      // Start coincident with a move in PLAY: move wins, start ignored
      bus.move_amt  = 3'd1;
      bus.btn_take  = 1'b1;
      bus.btn_start = 1'b1;
      cyc();
      bus.btn_take  = 1'b0;
      bus.btn_start = 1'b0;
      check("start_move_pile", bus.pile_size, 19);
      check("start_move_turn", bus.plr_turn,  1);
      do_take(1);
      check("still_play_pile", bus.pile_size, 18);

      // Hidden-pile timing
      bus.hide_mode = 1'b1;
      set_cfg(20, 3, 2);
      do_reset();
      do_ticks(3);
      check("hide_setup", bus.hide, 0);
      do_start();
      check("hide_entry", bus.hide, 0);
      do_ticks(2);
      check("hide_2ticks", bus.hide, 0);
      do_ticks(1);
      check("hide_3ticks", bus.hide, 1);
      do_ticks(1);
      check("hide_sat", bus.hide, 1);
      bus.hide_mode = 1'b0;
      do_take(1);
      check("hide_clear",      bus.hide,      0);
      check("hide_clear_pile", bus.pile_size, 19);
      do_ticks(2);
      check("hide_re_2ticks", bus.hide, 0);
      do_ticks(1);
      check("hide_re_3ticks", bus.hide, 1);
      do_take(0);
      check("hide_bad_err",  bus.move_err, 1);
      check("hide_bad_hide", bus.hide,     1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
